// File: rtl/user_io_event_queue.sv
// Debounces 10 user-I/O levels and queues one snapshot word per change into a small FIFO.
// Define USER_IO_EVENT_TIMESTAMP_EN to build the prescaled timestamp carried in o_event_data[31:16].
module user_io_event_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 160_000,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned TS_DIV          = 16_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [5:0]  i_button,
    input  logic [3:0]  i_link_pow,
    output logic [9:0]  o_state,
    output logic        o_event_valid,
    input  logic        i_event_ready,
    output logic [31:0] o_event_data,
    output logic        o_overflow
);

    localparam int unsigned NUM_IN = 10;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IN-1:0] raw;
    logic [CNT_W-1:0]  cnt [NUM_IN];
    logic [NUM_IN-1:0] flip;
    logic [NUM_IN-1:0] state_next;
    logic              push;
    logic [15:0]       ts;
    logic [31:0]       word;

    assign raw = {i_link_pow, i_button};

    // Bits whose raw level has differed long enough to be accepted on this edge
    always_comb begin
        flip = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            flip[i] = (raw[i] != o_state[i]) && (cnt[i] == CNT_LAST);
        end
    end

    assign state_next = o_state ^ flip;
    assign push       = |flip;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
            o_state <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (raw[i] == o_state[i] || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            o_state <= state_next;
        end
    end

`ifdef USER_IO_EVENT_TIMESTAMP_EN
    localparam int unsigned PRE_W = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TS_DIV - 1);

    logic [PRE_W-1:0] presc;

    // Free-running tick counter; the 16-bit timestamp rolls over naturally
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc <= '0;
            ts    <= '0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
            ts    <= ts + 16'd1;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end
`else
    // Timestamp field is tied off; TS_DIV has no effect in this build
    assign ts = 16'(TS_DIV) & 16'h0000;
`endif

    assign word = {ts, 6'd0, state_next};

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] rptr_next;
    logic             full;
    logic             pop;
    logic             wr;
    logic             drop;

    assign full      = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                       (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign pop       = o_event_valid && i_event_ready;
    assign wr        = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign rptr_next = rptr + PTR_W'(pop);

    always_ff @(posedge i_clk) begin
        if (!i_reset && wr) begin
            mem[wptr[ADDR_W-1:0]] <= word;
        end
    end

    // Head register compares against the pre-write pointer, so a fresh word shows one cycle after its push
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wptr          <= '0;
            rptr          <= '0;
            o_event_valid <= 1'b0;
            o_event_data  <= '0;
            o_overflow    <= 1'b0;
        end else begin
            if (wr) begin
                wptr <= wptr + PTR_W'(1);
            end
            rptr          <= rptr_next;
            o_event_valid <= (rptr_next != wptr);
            if (rptr_next != wptr) begin
                o_event_data <= mem[rptr_next[ADDR_W-1:0]];
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (pop) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_user_io_event_queue.sv
// Directed bench for user_io_event_queue with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, TS_DIV=2.
module tb_user_io_event_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  button;
    logic [3:0]  link_pow;
    logic [9:0]  state;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    logic [5:0]  ovf_btn  [5] = '{6'h21, 6'h23, 6'h27, 6'h2F, 6'h3F};
    logic [9:0]  ovf_snap [4] = '{10'h221, 10'h223, 10'h227, 10'h22F};
    logic [5:0]  full_btn [4] = '{6'h3E, 6'h3C, 6'h38, 6'h30};
    logic [9:0]  full_snap[4] = '{10'h23C, 10'h238, 10'h230, 10'h220};
    logic [15:0] ts1;
    logic [15:0] ts2;

    always #5 clk = ~clk;

    user_io_event_queue #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4),
        .TS_DIV         (2)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_button     (button),
        .i_link_pow   (link_pow),
        .o_state      (state),
        .o_event_valid(valid),
        .i_event_ready(ready),
        .o_event_data (data),
        .o_overflow   (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle(input logic [3:0] lp, input logic [5:0] btn);
        link_pow = lp;
        button   = btn;
        cyc(5);
    endtask

    initial begin
        reset = 1'b1; button = '0; link_pow = '0; ready = 1'b0;
        cyc(3);
        check("rst_state", 32'(state), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_data",  data,       32'h0);
        check("rst_ovf",   32'(ovf),   32'h0);
        reset = 1'b0;

        // Three-cycle glitch must be rejected
        button = 6'h02; cyc(3); button = 6'h00;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check("glitch_state", 32'(state), 32'h0);
            check("glitch_valid", 32'(valid), 32'h0);
        end

        button = 6'h01; cyc(3);
        check("deb_early", 32'(state), 32'h0);
        cyc(1);
        check("deb_state",     32'(state), 32'h001);
        check("deb_valid_lag", 32'(valid), 32'h0);
        cyc(1);
        check("deb_valid", 32'(valid),      32'h1);
        check("deb_data",  32'(data[9:0]),  32'h001);
        ready = 1'b1; cyc(1); ready = 1'b0;
        check("pop_empty", 32'(valid), 32'h0);

        // Simultaneous change on both ports yields one event
        link_pow = 4'h8; button = 6'h20; cyc(5);
        check("simul_state", 32'(state),     32'h220);
        check("simul_valid", 32'(valid),     32'h1);
        check("simul_data",  32'(data[9:0]), 32'h220);
        cyc(3);
        check("hold_valid", 32'(valid),     32'h1);
        check("hold_data",  32'(data[9:0]), 32'h220);
        ready = 1'b1; cyc(1); ready = 1'b0;
        check("simul_single", 32'(valid), 32'h0);

        // Five events into a four-deep queue
        for (int i = 0; i < 5; i++) begin
            settle(4'h8, ovf_btn[i]);
            check("ovf_flag", 32'(ovf), 32'(i == 4));
        end
        check("ovf_valid", 32'(valid),     32'h1);
        check("ovf_head",  32'(data[9:0]), 32'h221);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(valid),     32'h1);
            check("drain_data",  32'(data[9:0]), 32'(ovf_snap[i]));
            check("drain_ovf",   32'(ovf),       32'(i == 0));
            cyc(1);
        end
        check("drain_empty", 32'(valid), 32'h0);
        cyc(1);
        check("ready_empty", 32'(valid), 32'h0);
        ready = 1'b0;

        // Fill, then push and pop on the same edge
        for (int i = 0; i < 4; i++) begin
            settle(4'h8, full_btn[i]);
        end
        check("full_ovf0", 32'(ovf), 32'h0);
        button = 6'h20; cyc(3);
        ready = 1'b1; cyc(1); ready = 1'b0;
        check("pp_ovf",   32'(ovf),   32'h0);
        check("pp_state", 32'(state), 32'h220);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pp_valid", 32'(valid),     32'h1);
            check("pp_data",  32'(data[9:0]), 32'(full_snap[i]));
            cyc(1);
        end
        check("pp_empty", 32'(valid), 32'h0);
        ready = 1'b0;

        // Two events ten cycles apart
        button = 6'h21; cyc(10);
        button = 6'h23; cyc(5);
        check("ts_ev1_valid", 32'(valid),     32'h1);
        check("ts_ev1_data",  32'(data[9:0]), 32'h221);
        ts1 = data[31:16];
        ready = 1'b1; cyc(1); ready = 1'b0;
        check("ts_ev2_valid", 32'(valid),     32'h1);
        check("ts_ev2_data",  32'(data[9:0]), 32'h223);
        ts2 = data[31:16];
`ifdef USER_IO_EVENT_TIMESTAMP_EN
        check("ts_delta", 32'(16'(ts2 - ts1)), 32'd5);
`else
        check("ts1_zero", 32'(ts1), 32'h0);
        check("ts2_zero", 32'(ts2), 32'h0);
`endif

        // Reset with two queued and one change mid-debounce
        settle(4'h8, 6'h27);
        check("q2_valid", 32'(valid), 32'h1);
        button = 6'h2F; cyc(2);
        reset = 1'b1; cyc(1);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_state", 32'(state), 32'h0);
        check("mid_rst_data",  data,       32'h0);
        check("mid_rst_ovf",   32'(ovf),   32'h0);
        button = '0; link_pow = '0; cyc(2);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check("post_rst_state", 32'(state), 32'h0);
            check("post_rst_valid", 32'(valid), 32'h0);
        end

        // Inputs already active when reset releases
        reset = 1'b1; link_pow = 4'h8; button = 6'h3F; cyc(2);
        reset = 1'b0; cyc(3);
        check("held_early", 32'(state), 32'h0);
        cyc(1);
        check("held_state", 32'(state), 32'h23F);
        cyc(1);
        check("held_valid", 32'(valid),     32'h1);
        check("held_data",  32'(data[9:0]), 32'h23F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/user_io_event_queue.md
USER_IO_EVENT_QUEUE -- requirements
Module: user_io_event_queue

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 160_000, consecutive stable cycles required to accept a new input level (10 ms at 16 MHz); legal range 2..2^20-1.
REQ-002 Parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, 2..64.
REQ-003 Parameter TS_DIV, default 16_000, i_clk cycles per timestamp tick (1 ms at 16 MHz); legal range 1..2^16.
REQ-004 i_clk  input  1  clock; all logic on its rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_button  input  6  raw button levels from the TCA9555 poller, already in the i_clk domain; 1 = pressed.
REQ-007 i_link_pow  input  4  raw link-power levels from the same poller.
REQ-008 o_state  output  10  debounced levels, {link_pow[3:0], button[5:0]}.
REQ-009 o_event_valid  output  1  FIFO head is valid.
REQ-010 i_event_ready  input  1  consumer accepts the head word this cycle.
REQ-011 o_event_data  output  32  FIFO head: [31:16] timestamp, [15:10] zero, [9:0] debounced snapshot.
REQ-012 o_overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 Each of the 10 inputs has its own debounce counter: raw == stable -> counter clears to 0; raw != stable -> counter increments.
REQ-014 When a counter reaches DEBOUNCE_CYCLES-1 with raw != stable, stable takes raw on that edge and the counter clears; latency from first differing raw sample to o_state change is exactly DEBOUNCE_CYCLES cycles.
REQ-015 A raw glitch shorter than DEBOUNCE_CYCLES cycles leaves o_state unchanged and generates no event.
REQ-016 Timestamp: a prescaler counts 0..TS_DIV-1; on wrap a 16-bit timestamp increments, rolling 0xFFFF -> 0x0000.
REQ-017 In any cycle where one or more stable bits change, exactly one event is pushed, carrying the post-update snapshot and the current timestamp; simultaneous changes on several bits produce one event.
REQ-018 An event is written into the FIFO on the edge where the stable bits update; o_event_valid rises one cycle later when the FIFO was empty.
REQ-019 Handshake: the head is popped on each edge where o_event_valid && i_event_ready; o_event_data stays constant while o_event_valid && !i_event_ready.
REQ-020 i_event_ready with an empty FIFO has no effect.
REQ-021 Push into a full FIFO with no pop in the same cycle drops the new event, leaves FIFO contents unchanged, and sets o_overflow.
REQ-022 Push and pop in the same cycle while full: both occur, occupancy stays FIFO_DEPTH, o_overflow is not set.
REQ-023 Push and pop in the same cycle while at any other occupancy: both occur and occupancy is unchanged.
REQ-024 o_overflow clears on the first successful pop after it was set, i.e. the consumer sees it for at least one transferred word.
REQ-025 Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full and empty are derived from the pointer MSB comparison.

Reset
REQ-026 While i_reset is high: o_state = 0, all debounce counters = 0, prescaler = 0, timestamp = 0, FIFO empty, o_event_valid = 0, o_overflow = 0, o_event_data = 0.
REQ-027 Reset mid-debounce or with the FIFO non-empty discards all pending state; no event is generated for the return to o_state = 0.
REQ-028 After reset deassertion, an input held at 1 produces its first event after DEBOUNCE_CYCLES cycles.

Configuration
REQ-029 Macro USER_IO_EVENT_TIMESTAMP_EN: when defined, the prescaler and timestamp logic are built and o_event_data[31:16] carries the timestamp.
REQ-030 When USER_IO_EVENT_TIMESTAMP_EN is undefined, no prescaler or timestamp logic is built, o_event_data[31:16] is constant 0, TS_DIV is ignored, and all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, TS_DIV=2, timestamp enabled)
REQ-031 Bench: i_button=6'h01 held for 4 cycles -> o_state=10'h001 on cycle 4; one event with data[9:0]=10'h001; o_event_valid rises the next cycle.
REQ-032 Bench: i_button=6'h02 for 3 cycles then 0 -> o_state stays 0, o_event_valid stays 0.
REQ-033 Bench: i_link_pow and i_button change on the same cycle to 4'h8 and 6'h20 -> exactly one event with data[9:0]=10'h220.
REQ-034 Bench: i_event_ready=0 and 5 distinct debounced changes -> 4 events stored, 5th dropped, o_overflow=1; pop all 4 -> overflow clears on first pop, snapshots in order.
REQ-035 Bench: FIFO full with push and pop on the same edge -> occupancy stays 4, o_overflow stays 0, new snapshot appears last.
REQ-036 Bench: event at t=0, second event 10 cycles later -> timestamps differ by 5; reset asserted with 2 queued -> o_event_valid=0 the next cycle, no event for the return to 0.
